// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle of pwm_multi_ch: duty and enable inputs, PWM outputs and timebase strobes.
interface pwm_multi_ch_if #(
   parameter int NUM_CH   = 4,
   parameter int RES_BITS = 8
);
   logic [NUM_CH*RES_BITS-1:0] duty;
   logic                       duty_load;
   logic [NUM_CH-1:0]          ch_enable;
   logic [NUM_CH-1:0]          pwm_out;
   logic                       period_start;
   logic                       tick_1MHz;

   modport master (
      output duty, duty_load, ch_enable,
      input  pwm_out, period_start, tick_1MHz
   );

   modport slave (
      input  duty, duty_load, ch_enable,
      output pwm_out, period_start, tick_1MHz
   );
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler/period counter, double-buffered duty, glitch-free outputs.
// Define PWM_CENTER_ALIGN_EN for a center-aligned up/down counter; default is edge-aligned.
module pwm_multi_ch #(
   parameter int NUM_CH    = 4,
   parameter int RES_BITS  = 8,
   parameter int PRESC_DIV = 50
) (
   input logic           clk_50MHz,
   input logic           reset,
   pwm_multi_ch_if.slave bus
);
   localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

   typedef logic [RES_BITS-1:0] duty_t;
   localparam duty_t MAX = '1;
   localparam duty_t ONE = duty_t'(1);

   logic [PW-1:0]     presc_q, presc_d;
   duty_t             cnt_q, cnt_d;
   duty_t             pend_q [NUM_CH];
   duty_t             pend_d [NUM_CH];
   duty_t             act_q  [NUM_CH];
   duty_t             act_d  [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              tick_q, tick_d;
   logic              ps_q, ps_d;
   logic              presc_wrap;
`ifdef PWM_CENTER_ALIGN_EN
   logic              down_q, down_d;
`endif

   // The cycle in which period_start is high is the boundary: duty and enables latched
   // there apply from count 0 of the new period, since the output compare uses the _d values.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      presc_wrap = (presc_q == PRESC_LAST);
      presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
      tick_d     = presc_wrap;
      cnt_d      = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
      down_d = down_q;
      ps_d   = presc_wrap && down_q && (cnt_q == ONE);
      if (presc_wrap) begin
         if (!down_q) begin
            if (cnt_q == MAX) begin
               cnt_d  = MAX - ONE;
               down_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end else begin
            if (cnt_q == ONE) begin
               cnt_d  = '0;
               down_d = 1'b0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
      end
`else
      ps_d = presc_wrap && (cnt_q == MAX);
      if (presc_wrap) begin
         cnt_d = cnt_q + ONE;
      end
`endif

      // A falling enable clears the latched enable at once; a rising one waits for the boundary.
      en_d = ps_q ? bus.ch_enable : (en_q & bus.ch_enable);

      for (int i = 0; i < NUM_CH; i++) begin
         pend_d[i] = bus.duty_load ? bus.duty[i*RES_BITS +: RES_BITS] : pend_q[i];
         act_d[i]  = ps_q ? pend_d[i] : act_q[i];
         pwm_d[i]  = en_d[i] && ((act_d[i] == MAX) || (cnt_q < act_d[i]));
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         // NOTE: the duty registers are a handful of flops, so they are reset like the rest of the state.
         presc_q <= '0;
         cnt_q   <= '0;
         pend_q  <= '{default: '0};
         act_q   <= '{default: '0};
         en_q    <= '0;
         pwm_q   <= '0;
         tick_q  <= 1'b0;
         ps_q    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         down_q  <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         en_q    <= en_d;
         pwm_q   <= pwm_d;
         tick_q  <= tick_d;
         ps_q    <= ps_d;
`ifdef PWM_CENTER_ALIGN_EN
         down_q  <= down_d;
`endif
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.period_start = ps_q;
   assign bus.tick_1MHz    = tick_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: per-period expected high-clock counts from a time-domain model.
module tb_pwm_multi_ch;
   localparam int NUM_CH    = 4;
   localparam int RES_BITS  = 6;
   localparam int PRESC_DIV = 5;
   localparam int MAX       = (1 << RES_BITS) - 1;
`ifdef PWM_CENTER_ALIGN_EN
   localparam int PTICKS = 2 * MAX;
`else
   localparam int PTICKS = 1 << RES_BITS;
`endif
   localparam int P     = PTICKS * PRESC_DIV;
   localparam int N_PER = 30;
   localparam int VW    = NUM_CH * RES_BITS;

   logic clk = 1'b0;
   logic reset;

   pwm_multi_ch_if #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS)) bus ();

   pwm_multi_ch #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS), .PRESC_DIV(PRESC_DIV)) dut (
      .clk_50MHz (clk),
      .reset     (reset),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;
   int exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Clocks in one period (offsets 0..upto-1 from the boundary) where the counter value is below a.
   function automatic int high_count(input int a, input int upto);
      int n = 0;
      for (int j = 0; j < upto; j++) begin
         int t = j / PRESC_DIV;
         int v;
`ifdef PWM_CENTER_ALIGN_EN
         v = (t <= MAX) ? t : 2 * MAX - t;
`else
         v = t;
`endif
         if (a == MAX || v < a) n++;
      end
      return n;
   endfunction

   function automatic logic [VW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      logic [VW-1:0] v;
      v = '0;
      v[0*RES_BITS +: RES_BITS] = RES_BITS'(c0);
      v[1*RES_BITS +: RES_BITS] = RES_BITS'(c1);
      v[2*RES_BITS +: RES_BITS] = RES_BITS'(c2);
      v[3*RES_BITS +: RES_BITS] = RES_BITS'(c3);
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      int sel;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel = int'($urandom_range(0, 7));
         if (sel == 0)      v[i*RES_BITS +: RES_BITS] = '0;
         else if (sel == 1) v[i*RES_BITS +: RES_BITS] = RES_BITS'(MAX);
         else               v[i*RES_BITS +: RES_BITS] = RES_BITS'($urandom_range(0, MAX));
      end
      return v;
   endfunction

   // Monitor: timebase spacing checks and per-period high-clock accounting against the queue.
   int acc[NUM_CH];
   bit prev_ps   = 1'b0;
   bit seen      = 1'b0;
   int last_tick = 0;
   int last_ps   = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.tick_1MHz) begin
            check("tick_spacing", cyc - last_tick, PRESC_DIV);
            last_tick = cyc;
         end
         if (bus.period_start) begin
            check("ps_with_tick", int'(bus.tick_1MHz), 1);
            check("period_spacing", cyc - last_ps, P);
            last_ps = cyc;
         end
         if (prev_ps) begin
            if (seen) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (exp_q.size() == 0) check("missing_expectation", 1, 0);
                  else check($sformatf("ch%0d_high_clocks", i), acc[i], exp_q.pop_front());
               end
            end
            seen = 1'b1;
            for (int i = 0; i < NUM_CH; i++) acc[i] = 0;
         end
         for (int i = 0; i < NUM_CH; i++) acc[i] += int'(bus.pwm_out[i]);
         prev_ps = bus.period_start;
      end
   end

   initial begin
      logic [VW-1:0]     bduty, mduty;
      logic [NUM_CH-1:0] en;
      bit                bload, mload;
      int                moff;
      int                drop[NUM_CH];
      int                rais[NUM_CH];
      int                pend[NUM_CH];
      int                act[NUM_CH];
      int                lo;

      reset         = 1'b1;
      bus.duty      = '0;
      bus.duty_load = 1'b0;
      bus.ch_enable = '1;
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         check("reset_hold_quiet", int'({bus.pwm_out, bus.period_start, bus.tick_1MHz}), 0);
      end
      reset  = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < NUM_CH; i++) pend[i] = 0;

      for (int k = 0; k <= N_PER; k++) begin
         bload = 1'b0; mload = 1'b0; moff = 1;
         bduty = '0;   mduty = '0;   en = '1;
         for (int i = 0; i < NUM_CH; i++) begin
            drop[i] = P;
            rais[i] = P;
         end

         if (k == 0) begin
            mload = 1'b1; moff = 10; mduty = pack4(16, 32, 48, MAX);
         end else if (k == 2) begin
            mload = 1'b1; moff = 100; mduty = pack4(8, 32, 48, MAX);
         end else if (k == 3) begin
            bload = 1'b1; bduty = pack4(8, 4, 48, MAX);
         end else if (k == 4) begin
            drop[2] = 50; rais[2] = 150;
         end else if (k == 6) begin
            bload = 1'b1; bduty = pack4(0, 4, 48, MAX);
         end else if (k >= 9) begin
            bload = ($urandom_range(0, 3) == 0);
            bduty = rand_vec();
            mload = ($urandom_range(0, 1) == 1);
            moff  = int'($urandom_range(1, P - 1));
            mduty = rand_vec();
            for (int i = 0; i < NUM_CH; i++) begin
               en[i] = ($urandom_range(0, 5) != 0);
               if (en[i] && $urandom_range(0, 3) == 0) drop[i] = int'($urandom_range(1, P - 1));
               lo = (en[i] ? drop[i] : 0) + 1;
               if ((!en[i] || drop[i] < P) && lo <= P - 1 && $urandom_range(0, 1) == 1)
                  rais[i] = int'($urandom_range(lo, P - 1));
            end
         end

         for (int i = 0; i < NUM_CH; i++) begin
            act[i] = bload ? int'(bduty[i*RES_BITS +: RES_BITS]) : pend[i];
            if (bload) pend[i] = act[i];
            if (k > 0) exp_q.push_back(en[i] ? high_count(act[i], drop[i]) : 0);
         end

         for (int o = 0; o < P; o++) begin
            if (k == 0 && o < 2)
               check("post_reset_quiet", int'({bus.pwm_out, bus.period_start, bus.tick_1MHz}), 0);
            bus.duty_load = 1'b0;
            bus.duty      = VW'($urandom());
            if (o == 0) begin
               bus.ch_enable = en;
               if (bload) begin
                  bus.duty      = bduty;
                  bus.duty_load = 1'b1;
               end
            end
            if (mload && o == moff) begin
               bus.duty      = mduty;
               bus.duty_load = 1'b1;
               for (int i = 0; i < NUM_CH; i++) pend[i] = int'(mduty[i*RES_BITS +: RES_BITS]);
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (o == drop[i]) bus.ch_enable[i] = 1'b0;
               if (o == rais[i]) bus.ch_enable[i] = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (k == 4 && o == 49)  check("ch2_high_before_drop", int'(bus.pwm_out[2]), 1);
            if (k == 4 && o == 50)  check("ch2_low_after_drop", int'(bus.pwm_out[2]), 0);
            if (k == 4 && o == 150) check("ch2_low_after_reraise", int'(bus.pwm_out[2]), 0);
         end
      end

      // Boundary load of full duty on every channel, then a mid-operation reset.
      bus.duty      = pack4(MAX, MAX, MAX, MAX);
      bus.duty_load = 1'b1;
      bus.ch_enable = '1;
      @(posedge clk); #1; cyc++;
      bus.duty_load = 1'b0;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1; cyc++;
      end
      check("all_high_before_reset", int'(bus.pwm_out), (1 << NUM_CH) - 1);
      mon_en = 1'b0;
      reset  = 1'b1;
      @(posedge clk); #1; cyc++;
      check("reset_mid_op_quiet", int'({bus.pwm_out, bus.period_start, bus.tick_1MHz}), 0);
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1; cyc++;
         check("duty_lost_after_reset", int'(bus.pwm_out), 0);
      end
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised multi-channel PWM generator that succeeds the single-channel 4-bit PWM block.
- One shared prescaler and period counter drive NUM_CH independent compare channels with configurable resolution.
- Duty values are double-buffered and only take effect at period boundaries, so outputs are glitch-free.
- Sits between the control logic and the motor/LED drivers, clocked from the 50 MHz system clock.

Parameters:
NUM_CH, 4, number of PWM channels
RES_BITS, 8, duty/counter resolution in bits; MAX = 2^RES_BITS - 1
PRESC_DIV, 50, clk_50MHz cycles per counter tick (50 gives a 1 MHz tick); must be >= 2

Ports:
clk_50MHz  input  1  system clock, all logic on its rising edge
reset  input  1  synchronous, active-high reset
duty  input  NUM_CH*RES_BITS  packed duty values; channel i occupies bits [i*RES_BITS +: RES_BITS]
duty_load  input  1  single-cycle strobe; captures all of duty into the pending registers
ch_enable  input  NUM_CH  per-channel enable
pwm_out  output  NUM_CH  registered PWM outputs
period_start  output  1  one-cycle pulse at each period boundary
tick_1MHz  output  1  one-cycle prescaler tick pulse

Behaviour:
- One clock domain, clk_50MHz. Reset is synchronous and active-high, sampled on the rising edge.
- Reset state:
  - prescaler count, period count, pending duty, active duty and active enable are all 0.
  - pwm_out, period_start and tick_1MHz are all 0.
- Prescaler:
  - Counts 0..PRESC_DIV-1, then wraps to 0.
  - tick_1MHz = 1 (registered) in the cycle after the prescaler reaches PRESC_DIV-1.
- Period counter:
  - Advances by 1 on each tick and wraps from MAX to 0.
  - Period = 2^RES_BITS ticks = PRESC_DIV*2^RES_BITS clocks.
- Boundary: the tick on which the counter wraps MAX->0. period_start pulses in the same cycle as that tick_1MHz.
- Duty buffering:
  - duty_load=1 copies duty into pending[] on that clock.
  - At the boundary, active[] <= pending[].
  - If duty_load coincides with the boundary clock, active[] takes the new duty value directly, and pending is updated as well.
  - duty_load mid-period never changes the current period.
- Compare, per channel i (count = period counter):
  - active[i] == 0 -> output low for the whole period.
  - active[i] == MAX -> output high for the whole period, with no 1-tick low gap (100% duty).
  - Otherwise the output is high while count < active[i], i.e. active[i] ticks high per period.
- Output latency: pwm_out[i] is registered and reflects a count change 1 clock after the count changes.
- Enable:
  - Falling ch_enable[i] forces pwm_out[i] low on the next clock. This takes effect immediately.
  - Rising ch_enable[i] is latched into the active enable only at the next boundary, so no partial first pulse is produced.
- Reset mid-operation: returns to the reset state on the next edge. Pending and active duty are lost; outputs go low within 1 clock.
- The counters never stall. ch_enable and duty_load have no effect on the timebase.

Optional Feature:
PWM_CENTER_ALIGN_EN
- Defined (center-aligned mode):
  - The period counter counts up 0..MAX, then down MAX-1..1, giving a period of 2*MAX ticks.
  - The boundary and period_start occur when the counter steps from 1 to 0 on the way down.
  - Output is high while count < active[i]. The pulse is symmetric about count 0, with high time 2*active[i]-1 ticks.
  - active[i] == MAX -> constant high; active[i] == 0 -> constant low.
- Undefined: edge-aligned up-counter as specified above.

Test Plan:
1. Assert reset for 3 clocks with ch_enable=4'hF -> pwm_out=0, period_start=0, tick_1MHz=0 throughout, and for 2 clocks after release.
2. Defaults; duty_load with ch0=64, ch1=128, ch2=192, ch3=255; enable all -> from the second period on:
   - ch0 high 3200 of 12800 clocks, ch1 6400, ch2 9600.
   - ch3 constantly high.
   - period_start spacing is exactly 12800 clocks.
   - tick_1MHz spacing is exactly 50 clocks.
3. Mid-period duty_load changing ch0 from 64 to 32 -> the current period still shows 3200 high clocks; the following period shows 1600.
4. duty_load asserted exactly on the period_start clock with ch1=16 -> that same period shows 800 high clocks.
5. Drop ch_enable[2] mid-pulse -> pwm_out[2]=0 on the next clock. Re-raise it mid-period -> it stays low until the next period_start, then follows its duty.
6. duty ch0=0 -> pwm_out[0] never high across 3 periods. With PWM_CENTER_ALIGN_EN defined and ch0=64 -> period is 510 ticks, high time is 127 ticks, centred on the boundary.
